// File: rtl/move_selector_pkg.sv
// Shared definitions for the move selector: FSM state codes, piece encoding
// constants and small square/coordinate helpers.
package move_selector_pkg;

  // FSM state codes; these two bits appear directly on moveData[13:12].
  typedef enum logic [1:0] {
    ST_PICK_SRC = 2'b00,
    ST_PICK_DST = 2'b01,
    ST_ISSUE    = 2'b10,
    ST_UNUSED   = 2'b11
  } selState_t;

  // Piece nibble layout: [3] colour (1 = black), [2:0] type, 4'h0 = empty.
  localparam int        COLOUR_BIT = 3;
  localparam logic [3:0] EMPTY     = 4'h0;

  // Button vector positions inside move_selector.
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;
  localparam int NUM_BTN = 5;

  // Row and column of a 0..63 square index (index = row*8 + col).
  function automatic logic [2:0] sqRow(input logic [5:0] sq);
    return sq[5:3];
  endfunction

  function automatic logic [2:0] sqCol(input logic [5:0] sq);
    return sq[2:0];
  endfunction

  // One step along a row or column; wraps modulo 8 or saturates at the edge.
  function automatic logic [2:0] stepCoord(input logic [2:0] coord,
                                           input logic       inc,
                                           input logic       wrapEn);
    logic [2:0] result;
    result = coord;
    if (inc) begin
      if (coord != 3'd7 || wrapEn) result = coord + 3'd1;
    end else begin
      if (coord != 3'd0 || wrapEn) result = coord - 3'd1;
    end
    return result;
  endfunction

  // A piece belongs to the side to move when it is present and its colour matches.
  function automatic logic isOwnPiece(input logic [3:0] piece, input logic turn);
    return (piece != EMPTY) && (piece[COLOUR_BIT] == turn);
  endfunction

endpackage

// File: rtl/move_selector_rise_detect.sv
// Rising-edge detector for one debounced button level. The previous-level
// register resets high so a button held through reset never produces a pulse.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prevLevel;

  // Remember last cycle's level; forced high in reset to mask held buttons.
  always_ff @(posedge clk) begin
    if (reset) prevLevel <= 1'b1;
    else       prevLevel <= level;
  end

  assign pulse = level & ~prevLevel;

endmodule

// File: rtl/move_selector.sv
// Cursor/selection front end for the chess game logic. Turns button presses
// into an 8x8 cursor, a source/destination pick and a valid/ready move request,
// and exports {state, src, cursor} for the VGA highlight painter.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_PICK_SRC | cursor moves; centre on an own piece selects it as source
// ST_PICK_DST | cursor moves; centre picks dest, reselects, or cancels
// ST_ISSUE    | move_valid high, buttons ignored until move_ready
// ST_UNUSED   | never entered on purpose; recovers to ST_PICK_SRC
module move_selector
  import move_selector_pkg::*;
#(
  parameter bit         WRAP     = 1'b1,
  parameter logic [5:0] RESET_SQ = 6'd52
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btnc,
  input  logic         btnu,
  input  logic         btnd,
  input  logic         btnl,
  input  logic         btnr,
  input  logic [255:0] board,
  input  logic         turn,
  output logic         move_valid,
  output logic [5:0]   move_src,
  output logic [5:0]   move_dst,
  input  logic         move_ready,
  output logic         reject,
  output logic [13:0]  move_data
);

  logic [NUM_BTN-1:0] btnLevel;
  logic [NUM_BTN-1:0] btnPress;

  selState_t  state;
  logic [5:0] cursor;
  logic [5:0] srcSq;
  logic [5:0] dstSq;
  logic       moveValid;
  logic       rejectPulse;

  logic [7:0] pieceBit;
  logic [3:0] pieceAtCursor;
  logic       ownAtCursor;
  logic       centrePress;
  logic [3:0] dirPress;
  logic [2:0] nextRow;
  logic [2:0] nextCol;
  logic [5:0] nextCursor;

  assign btnLevel[BTN_C] = btnc;
  assign btnLevel[BTN_U] = btnu;
  assign btnLevel[BTN_D] = btnd;
  assign btnLevel[BTN_L] = btnl;
  assign btnLevel[BTN_R] = btnr;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_rise
    rise_detect uRise (
      .clk   (clk),
      .reset (reset),
      .level (btnLevel[b]),
      .pulse (btnPress[b])
    );
  end

  assign centrePress = btnPress[BTN_C];
  assign dirPress    = {btnPress[BTN_R], btnPress[BTN_L], btnPress[BTN_D], btnPress[BTN_U]};

  assign pieceBit      = {cursor, 2'b00};
  assign pieceAtCursor = board[pieceBit +: 4];
  assign ownAtCursor   = isOwnPiece(pieceAtCursor, turn);

  // Cursor step for exactly one direction press; simultaneous directions cancel out.
  always_comb begin
    nextRow = sqRow(cursor);
    nextCol = sqCol(cursor);
    case (dirPress)
      4'b0001: nextRow = stepCoord(sqRow(cursor), 1'b0, WRAP);
      4'b0010: nextRow = stepCoord(sqRow(cursor), 1'b1, WRAP);
      4'b0100: nextCol = stepCoord(sqCol(cursor), 1'b0, WRAP);
      4'b1000: nextCol = stepCoord(sqCol(cursor), 1'b1, WRAP);
      default: ;
    endcase
    nextCursor = {nextRow, nextCol};
  end

  // Selection FSM; a centre press takes priority over any direction press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PICK_SRC;
      cursor      <= RESET_SQ;
      srcSq       <= 6'd0;
      dstSq       <= 6'd0;
      moveValid   <= 1'b0;
      rejectPulse <= 1'b0;
    end else begin
      rejectPulse <= 1'b0;
      case (state)
        ST_PICK_SRC: begin
          if (centrePress) begin
            if (ownAtCursor) begin
              srcSq <= cursor;
              state <= ST_PICK_DST;
            end else begin
              rejectPulse <= 1'b1;
            end
          end else begin
            cursor <= nextCursor;
          end
        end
        ST_PICK_DST: begin
          if (centrePress) begin
            if (cursor == srcSq) begin
              state <= ST_PICK_SRC;
            end else if (ownAtCursor) begin
              srcSq <= cursor;
            end else begin
              dstSq     <= cursor;
              moveValid <= 1'b1;
              state     <= ST_ISSUE;
            end
          end else begin
            cursor <= nextCursor;
          end
        end
        ST_ISSUE: begin
          if (moveValid && move_ready) begin
            moveValid <= 1'b0;
            state     <= ST_PICK_SRC;
          end
        end
        default: begin
          moveValid <= 1'b0;
          state     <= ST_PICK_SRC;
        end
      endcase
    end
  end

  assign move_valid = moveValid;
  assign move_src   = srcSq;
  assign move_dst   = dstSq;
  assign reject     = rejectPulse;
  assign move_data  = {state, srcSq, cursor};

endmodule

// File: tb/tb_move_selector.sv
// Directed bench for move_selector: cursor movement with both edge modes,
// source/destination picking, handshake hold-off, rejects and reset corners.
module tb_move_selector;

  logic         clk = 1'b0;
  logic         reset;
  logic         btnc, btnu, btnd, btnl, btnr;
  logic [255:0] board;
  logic         turn;
  logic         moveReady;

  logic         moveValid, moveValidSat;
  logic [5:0]   moveSrc, moveSrcSat;
  logic [5:0]   moveDst, moveDstSat;
  logic         reject, rejectSat;
  logic [13:0]  moveData, moveDataSat;

  int nCompared   = 0;
  int nMismatched = 0;

  move_selector #(.WRAP(1'b1), .RESET_SQ(6'd52)) dut (
    .clk(clk), .reset(reset),
    .btnc(btnc), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
    .board(board), .turn(turn),
    .move_valid(moveValid), .move_src(moveSrc), .move_dst(moveDst),
    .move_ready(moveReady), .reject(reject), .move_data(moveData)
  );

  move_selector #(.WRAP(1'b0), .RESET_SQ(6'd52)) dutSat (
    .clk(clk), .reset(reset),
    .btnc(btnc), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
    .board(board), .turn(turn),
    .move_valid(moveValidSat), .move_src(moveSrcSat), .move_dst(moveDstSat),
    .move_ready(moveReady), .reject(rejectSat), .move_data(moveDataSat)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBtn(input int idx, input logic val);
    case (idx)
      0: btnc = val;
      1: btnu = val;
      2: btnd = val;
      3: btnl = val;
      default: btnr = val;
    endcase
  endtask

  // Press and release a button, leaving one idle cycle so the next press is a fresh edge.
  task automatic pressBtn(input int idx, input int times);
    for (int k = 0; k < times; k++) begin
      setBtn(idx, 1'b1);
      tick();
      setBtn(idx, 1'b0);
      tick();
    end
  endtask

  task automatic checkSel(input string tag, input logic [1:0] expState,
                          input logic [5:0] expSrc, input logic [5:0] expCur);
    checkVal({tag, "_state"},  moveData[13:12], expState);
    checkVal({tag, "_src"},    moveSrc,         expSrc);
    checkVal({tag, "_cursor"}, moveData[5:0],   expCur);
  endtask

  logic [13:0] expData;

  initial begin
    reset = 1'b1; moveReady = 1'b0; turn = 1'b0;
    btnc = 0; btnu = 0; btnd = 0; btnl = 0; btnr = 0;
    board = '0;
    board[52*4 +: 4] = 4'h1;  // white pawn
    board[60*4 +: 4] = 4'h6;  // white king
    board[12*4 +: 4] = 4'h9;  // black pawn

    tick(); tick();
    reset = 1'b0;
    tick();
    checkSel("rst", 2'b00, 6'd0, 6'd52);
    checkVal("rst_dst", moveDst, 6'd0);
    checkVal("rst_valid", moveValid, 1'b0);
    checkVal("rst_reject", reject, 1'b0);

    // Cursor movement and edge behaviour.
    pressBtn(4, 3);
    checkVal("right3_wrap", moveData[5:0], 6'd55);
    checkVal("right3_sat", moveDataSat[5:0], 6'd55);
    pressBtn(4, 1);
    checkVal("right_edge_wrap", moveData[5:0], 6'd48);
    checkVal("right_edge_sat", moveDataSat[5:0], 6'd55);
    pressBtn(4, 4);
    checkVal("back_to_52", moveData[5:0], 6'd52);

    // Source pick on the white pawn.
    pressBtn(0, 1);
    expData = {2'b01, 6'd52, 6'd52};
    checkVal("pick_src_data", moveData, expData);
    checkVal("pick_src_src", moveSrc, 6'd52);

    // Destination two rows up, then hold off the handshake.
    pressBtn(1, 2);
    checkVal("dst_cursor", moveData[5:0], 6'd36);
    pressBtn(0, 1);
    checkVal("issue_valid", moveValid, 1'b1);
    checkVal("issue_dst", moveDst, 6'd36);
    checkVal("issue_state", moveData[13:12], 2'b10);
    for (int i = 0; i < 5; i++) begin
      btnr = (i % 2 == 0);
      btnc = (i == 2);
      tick();
      checkVal("hold_valid", moveValid, 1'b1);
      checkVal("hold_src", moveSrc, 6'd52);
      checkVal("hold_dst", moveDst, 6'd36);
      checkVal("hold_cursor", moveData[5:0], 6'd36);
      checkVal("hold_state", moveData[13:12], 2'b10);
    end
    btnr = 1'b0; btnc = 1'b0;
    moveReady = 1'b1;
    tick();
    moveReady = 1'b0;
    checkVal("accept_valid", moveValid, 1'b0);
    checkSel("accept", 2'b00, 6'd52, 6'd36);
    checkVal("accept_dst", moveDst, 6'd36);

    // Reject on empty square: exactly one cycle.
    btnc = 1'b1;
    tick();
    checkVal("rej_empty_pulse", reject, 1'b1);
    checkVal("rej_empty_state", moveData[13:12], 2'b00);
    btnc = 1'b0;
    tick();
    checkVal("rej_empty_clear", reject, 1'b0);

    // Reject on opponent piece at square 12.
    pressBtn(1, 3);
    checkVal("to_12", moveData[5:0], 6'd12);
    btnc = 1'b1;
    tick();
    checkVal("rej_black_pulse", reject, 1'b1);
    btnc = 1'b0;
    tick();
    checkVal("rej_black_clear", reject, 1'b0);
    checkVal("rej_black_state", moveData[13:12], 2'b00);

    // Same square is legal for black; then cancel by picking the source again.
    turn = 1'b1;
    pressBtn(0, 1);
    checkSel("black_pick", 2'b01, 6'd12, 6'd12);
    pressBtn(0, 1);
    checkVal("black_cancel", moveData[13:12], 2'b00);
    turn = 1'b0;

    // Cancel and reselect with white.
    pressBtn(2, 5);
    pressBtn(0, 1);
    checkSel("w_pick", 2'b01, 6'd52, 6'd52);
    pressBtn(0, 1);
    checkVal("w_cancel", moveData[13:12], 2'b00);
    pressBtn(0, 1);
    pressBtn(2, 1);
    pressBtn(0, 1);
    checkSel("reselect", 2'b01, 6'd60, 6'd60);
    pressBtn(0, 1);
    checkVal("reselect_cancel", moveData[13:12], 2'b00);

    // Two directions together do nothing.
    btnu = 1'b1; btnl = 1'b1;
    tick();
    btnu = 1'b0; btnl = 1'b0;
    tick();
    checkVal("dual_dir", moveData[5:0], 6'd60);

    // Centre wins over a simultaneous direction.
    btnc = 1'b1; btnr = 1'b1;
    tick();
    btnc = 1'b0; btnr = 1'b0;
    tick();
    checkSel("centre_prio", 2'b01, 6'd60, 6'd60);
    pressBtn(0, 1);
    checkVal("centre_prio_cancel", moveData[13:12], 2'b00);

    // Centre held through reset must not select the pawn afterwards.
    btnc = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    checkSel("held_rst", 2'b00, 6'd0, 6'd52);
    checkVal("held_rst_reject", reject, 1'b0);
    btnc = 1'b0;
    tick();
    checkVal("held_rel_state", moveData[13:12], 2'b00);

    // Reset while a request is pending.
    pressBtn(0, 1);
    pressBtn(1, 1);
    pressBtn(0, 1);
    checkVal("pre_rst_valid", moveValid, 1'b1);
    checkVal("pre_rst_dst", moveDst, 6'd44);
    reset = 1'b1;
    tick();
    checkVal("mid_rst_valid", moveValid, 1'b0);
    checkSel("mid_rst", 2'b00, 6'd0, 6'd52);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
